// File: rtl/core_fetch.sv
// Instruction fetch stage: PC, 1-cycle-latency instruction memory interface,
// a 2-entry skid buffer for downstream stalls, and branch/jump redirect.
module core_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        STALL,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    output logic        IMEM_EN,
    output logic [31:0] IMEM_ADDR,
    input  logic [31:0] IMEM_DATA,
    output logic [31:0] INST,
    output logic [31:0] INST_PC,
    output logic        INST_VALID
);

    localparam int DEPTH = 2;

    logic [31:0] pc_reg;
    logic        pend_reg;
    logic [31:0] pend_pc_reg;
    logic [1:0]  cnt_reg;
    logic [31:0] buf_word_reg [DEPTH];
    logic [31:0] buf_pc_reg   [DEPTH];
    logic [31:0] inst_reg;
    logic [31:0] inst_pc_reg;
    logic        inst_valid_reg;

    logic [1:0]  avail;
    logic [1:0]  remain;
    logic        load;
    logic        from_buf;
    logic        shift;
    logic        push;
    logic [1:0]  cnt_after;
    logic [1:0]  cnt_next;
    logic [31:0] head_word;
    logic [31:0] head_pc;

    always_comb begin
        avail     = cnt_reg + {1'b0, pend_reg};
        load      = !STALL && (avail != 2'd0) && !REDIRECT;
        remain    = avail - {1'b0, load};
        IMEM_EN   = REDIRECT || (remain <= 2'd1);
        IMEM_ADDR = REDIRECT ? {REDIRECT_PC[31:2], 2'b00} : pc_reg;
        from_buf  = (cnt_reg != 2'd0);
        head_word = from_buf ? buf_word_reg[0] : IMEM_DATA;
        head_pc   = from_buf ? buf_pc_reg[0]   : pend_pc_reg;
        shift     = load && from_buf;
        cnt_after = cnt_reg - {1'b0, shift};
        // A returning word is buffered unless it bypasses straight to INST
        // or belongs to a flushed stream.
        push      = pend_reg && !(load && !from_buf) && !REDIRECT;
        cnt_next  = REDIRECT ? 2'd0 : cnt_after + {1'b0, push};
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            pc_reg      <= RESET_PC;
            pend_reg    <= 1'b0;
            pend_pc_reg <= 32'h0;
            cnt_reg     <= 2'd0;
        end else begin
            cnt_reg <= cnt_next;
            if (IMEM_EN) begin
                pend_reg    <= 1'b1;
                pend_pc_reg <= IMEM_ADDR;
                pc_reg      <= IMEM_ADDR + 32'd4;
            end else begin
                pend_reg <= 1'b0;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_buf
            localparam int SRC = (gi < DEPTH - 1) ? gi + 1 : gi;
            always_ff @(posedge CLK) begin
                if (push && (cnt_after == 2'(gi))) begin
                    buf_word_reg[gi] <= IMEM_DATA;
                    buf_pc_reg[gi]   <= pend_pc_reg;
                end else if (shift) begin
                    buf_word_reg[gi] <= buf_word_reg[SRC];
                    buf_pc_reg[gi]   <= buf_pc_reg[SRC];
                end
            end
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            inst_reg       <= NOP_INST;
            inst_pc_reg    <= 32'h0;
            inst_valid_reg <= 1'b0;
        end else if (REDIRECT) begin
            inst_reg       <= NOP_INST;
            inst_valid_reg <= 1'b0;
        end else if (load) begin
            inst_reg       <= head_word;
            inst_pc_reg    <= head_pc;
            inst_valid_reg <= 1'b1;
        end else if (!STALL) begin
            inst_reg       <= NOP_INST;
            inst_valid_reg <= 1'b0;
        end
    end

    assign INST       = inst_reg;
    assign INST_PC    = inst_pc_reg;
    assign INST_VALID = inst_valid_reg;

endmodule

// File: tb/tb_core_fetch.sv
// Self-checking bench for core_fetch: directed scenarios then random
// stall/redirect/reset traffic against a program-order stream model.
module tb_core_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        STALL = 1'b0;
    logic        REDIRECT = 1'b0;
    logic [31:0] REDIRECT_PC = 32'h0;
    logic        IMEM_EN;
    logic [31:0] IMEM_ADDR;
    logic [31:0] IMEM_DATA = 32'h0;
    logic [31:0] INST;
    logic [31:0] INST_PC;
    logic        INST_VALID;

    core_fetch #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
        .CLK(CLK), .RST_N(RST_N), .STALL(STALL), .REDIRECT(REDIRECT),
        .REDIRECT_PC(REDIRECT_PC), .IMEM_EN(IMEM_EN), .IMEM_ADDR(IMEM_ADDR),
        .IMEM_DATA(IMEM_DATA), .INST(INST), .INST_PC(INST_PC),
        .INST_VALID(INST_VALID)
    );

    always #5 CLK = ~CLK;

    // Memory content differs from the address so INST and INST_PC are distinguishable.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    always @(posedge CLK) if (IMEM_EN) IMEM_DATA <= mem_word(IMEM_ADDR);

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: the stage delivers program-order addresses of the current
    // stream, one per unstalled cycle, from the second cycle of the stream onward.
    bit          m_started = 0;
    int          m_age = 0;
    logic [31:0] m_base = 32'h0;
    int          m_issued = 0;
    int          m_delivered = 0;
    logic        m_valid = 1'b0;
    logic [31:0] m_inst = 32'h0;
    logic [31:0] m_inst_pc = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    endtask

    task automatic cycle(input logic rst_n, input logic stall, input logic redir,
                         input logic [31:0] rpc);
        logic        will_deliver;
        logic        exp_en;
        logic [31:0] exp_addr;
        logic [31:0] a;
        RST_N = rst_n; STALL = stall; REDIRECT = redir; REDIRECT_PC = rpc;
        #1;
        will_deliver = !stall && !redir && (m_age >= 1);
        exp_en   = redir || ((m_issued - m_delivered - int'(will_deliver)) <= 1);
        exp_addr = redir ? {rpc[31:2], 2'b00} : m_base + 32'(m_issued) * 32'd4;
        if (rst_n && m_started) begin
            chk("imem_en", {31'h0, IMEM_EN}, {31'h0, exp_en});
            if (exp_en) chk("imem_addr", IMEM_ADDR, exp_addr);
        end
        @(posedge CLK);
        if (!rst_n) begin
            m_started = 1; m_age = 0; m_base = RESET_PC;
            m_issued = 0; m_delivered = 0;
            m_valid = 1'b0; m_inst = NOP_INST; m_inst_pc = 32'h0;
        end else if (m_started) begin
            if (redir) begin
                m_base = {rpc[31:2], 2'b00}; m_issued = 1; m_delivered = 0; m_age = 1;
                m_valid = 1'b0; m_inst = NOP_INST;
            end else begin
                if (exp_en) m_issued++;
                if (will_deliver) begin
                    a = m_base + 32'(m_delivered) * 32'd4;
                    m_valid = 1'b1; m_inst = mem_word(a); m_inst_pc = a;
                    m_delivered++;
                end else if (!stall) begin
                    m_valid = 1'b0; m_inst = NOP_INST;
                end
                m_age++;
            end
        end
        @(negedge CLK);
        cyc++;
        if (m_started) begin
            chk("inst_valid", {31'h0, INST_VALID}, {31'h0, m_valid});
            chk("inst", INST, m_inst);
            chk("inst_pc", INST_PC, m_inst_pc);
        end
        $display("cyc %0d rst_n=%0b stall=%0b redir=%0b valid=%0b INST_PC=%h INST=%h",
                 cyc, rst_n, stall, redir, INST_VALID, INST_PC, INST);
    endtask

    initial begin
        @(negedge CLK);
        // Reset, then free run
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        for (int i = 0; i < 8; i++) cycle(1, 0, 0, 0);
        // Three-cycle stall mid-stream
        for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0);
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0);
        // Fill the buffer, then redirect to 0x100
        cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(1, 0, 1, 32'h100);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0);
        // Redirect together with stall
        cycle(1, 1, 1, 32'h100);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0);
        // Target near the top of the address space wraps to zero
        cycle(1, 0, 1, 32'hFFFF_FFFE);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0);
        // Reset with a word in flight and one buffered
        cycle(1, 1, 0, 0);
        cycle(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0);
        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic        r_rst;
            logic        r_stall;
            logic        r_redir;
            logic [31:0] r_pc;
            r_rst   = ($urandom_range(0, 99) >= 2);
            r_stall = ($urandom_range(0, 99) < 30);
            r_redir = ($urandom_range(0, 99) < 8);
            r_pc    = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15))
                                                  : $urandom;
            cycle(r_rst, r_stall, r_redir, r_pc);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
